// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
// Compares two WIDTH-bit unsigned operands MSB-first, one 2-bit digit per
// clock, through a single cascade compare slice. The running less/greater/
// equal flags live in registers between digits, and the final verdict is
// registered into lt/gt/eq on entry to DONE.

// One 2-bit cascade comparator slice. A decision already made by a more
// significant digit (lessIn/greaterIn) always wins over this digit.
module CompareSlice2 (
    input  logic [1:0] digitX_i,
    input  logic [1:0] digitY_i,
    input  logic       lessIn_i,
    input  logic       greaterIn_i,
    output logic       lessOut_o,
    output logic       greaterOut_o,
    output logic       equalOut_o
);

    // Pure combinational slice; a latched decision blocks the opposite flag.
    always_comb begin
        lessOut_o    = ~greaterIn_i & (lessIn_i | (digitX_i < digitY_i));
        greaterOut_o = ~lessIn_i & (greaterIn_i | (digitX_i > digitY_i));
        equalOut_o   = ~greaterIn_i & ~lessIn_i & (digitX_i == digitY_i);
    end

endmodule

module serial_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             lt_o,
    output logic             gt_o,
    output logic             eq_o
);

    localparam int DIGITS = WIDTH / 2;
    localparam int CNT_W  = ($clog2(DIGITS + 1) > 1) ? $clog2(DIGITS + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] xShift_q, xShift_d;
    logic [WIDTH-1:0] yShift_q, yShift_d;
    logic             runLess_q, runLess_d;
    logic             runGreater_q, runGreater_d;
    logic             runEqual_q, runEqual_d;
    logic [CNT_W-1:0] digitCnt_q, digitCnt_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;

    logic             sliceLess;
    logic             sliceGreater;
    logic             sliceEqual;

    // The slice always looks at the current top digit of both shifters.
    CompareSlice2 uSlice (
        .digitX_i     (xShift_q[WIDTH-1 -: 2]),
        .digitY_i     (yShift_q[WIDTH-1 -: 2]),
        .lessIn_i     (runLess_q),
        .greaterIn_i  (runGreater_q),
        .lessOut_o    (sliceLess),
        .greaterOut_o (sliceGreater),
        .equalOut_o   (sliceEqual)
    );

    // Next-state and datapath updates; everything holds unless a state acts on it.
    always_comb begin
        state_d      = state_q;
        xShift_d     = xShift_q;
        yShift_d     = yShift_q;
        runLess_d    = runLess_q;
        runGreater_d = runGreater_q;
        runEqual_d   = runEqual_q;
        digitCnt_d   = digitCnt_q;
        lt_d         = lt_q;
        gt_d         = gt_q;
        eq_d         = eq_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d      = RUN;
                    xShift_d     = x_i;
                    yShift_d     = y_i;
                    runLess_d    = 1'b0;
                    runGreater_d = 1'b0;
                    runEqual_d   = 1'b1;
                    digitCnt_d   = '0;
                end
            end
            RUN: begin
                runLess_d    = sliceLess;
                runGreater_d = sliceGreater;
                runEqual_d   = sliceEqual;
                xShift_d     = xShift_q << 2;
                yShift_d     = yShift_q << 2;
                digitCnt_d   = digitCnt_q + CNT_W'(1);
                if (digitCnt_q == LAST_DIGIT) begin
                    state_d = DONE;
                    lt_d    = sliceLess;
                    gt_d    = sliceGreater;
                    eq_d    = sliceEqual;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register; reset returns to IDLE and aborts any operation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shifters, running flags, digit counter and registered verdict.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            xShift_q     <= '0;
            yShift_q     <= '0;
            runLess_q    <= 1'b0;
            runGreater_q <= 1'b0;
            runEqual_q   <= 1'b0;
            digitCnt_q   <= '0;
            lt_q         <= 1'b0;
            gt_q         <= 1'b0;
            eq_q         <= 1'b0;
        end else begin
            xShift_q     <= xShift_d;
            yShift_q     <= yShift_d;
            runLess_q    <= runLess_d;
            runGreater_q <= runGreater_d;
            runEqual_q   <= runEqual_d;
            digitCnt_q   <= digitCnt_d;
            lt_q         <= lt_d;
            gt_q         <= gt_d;
            eq_q         <= eq_d;
        end
    end

    // Status decodes straight from the state register; results from their registers.
    always_comb begin
        busy_o = (state_q != IDLE);
        done_o = (state_q == DONE);
        lt_o   = lt_q;
        gt_o   = gt_q;
        eq_o   = eq_q;
    end

endmodule
